// File: rtl/calc_core_if.sv
// Operand/command and result signals between the calculator front end and calc_core.
// The master drives the switches and pulses; the slave (the core) returns the display value and flags.
interface calc_core_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] sw;
  logic [1:0]       op;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] display;
  logic             err;
  logic             busy;

  modport master (
    output sw, op, enter, clear,
    input  display, err, busy
  );

  modport slave (
    input  sw, op, enter, clear,
    output display, err, busy
  );
endinterface

// File: rtl/calc_core.sv
// Unsigned four-function calculator engine: latches A then B (with op) on enter pulses, then
// executes add/sub in one cycle or shift-add mul / restoring div over WIDTH iterations.
module calc_core #(
  parameter int unsigned WIDTH         = 8,
  parameter bit          ECHO_OPERANDS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  calc_core_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StA, StB, StExec} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d, busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0] add_sum, sub_diff, mul_sum, div_shift, div_trial;
  logic           iter_left;

  assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff  = {1'b0, a_q} - {1'b0, b_q};
  // hi:lo holds partial product (mul) or remainder:quotient (div).
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign iter_left = (cnt_q < CntW'(WIDTH));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    disp_d  = disp_q;
    op_d    = op_q;
    err_d   = err_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StA: begin
        if (bus.enter) begin
          a_d   = bus.sw;
          err_d = 1'b0;
          if (ECHO_OPERANDS) disp_d = bus.sw;
          state_d = StB;
        end
      end
      StB: begin
        if (bus.enter) begin
          b_d    = bus.sw;
          op_d   = bus.op;
          busy_d = 1'b1;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = (bus.op == 2'b11) ? a_q : bus.sw;
          if (ECHO_OPERANDS) disp_d = bus.sw;
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (op_q)
          2'b00: begin
            disp_d  = add_sum[WIDTH-1:0];
            err_d   = add_sum[WIDTH];
            busy_d  = 1'b0;
            state_d = StA;
          end
          2'b01: begin
            disp_d  = sub_diff[WIDTH-1:0];
            err_d   = sub_diff[WIDTH];
            busy_d  = 1'b0;
            state_d = StA;
          end
          2'b10: begin
            if (iter_left) begin
              hi_d  = mul_sum[WIDTH:1];
              lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
              cnt_d = cnt_q + 1'b1;
            end else begin
              disp_d  = lo_q;
              err_d   = |hi_q;
              busy_d  = 1'b0;
              state_d = StA;
            end
          end
          2'b11: begin
            if (b_q == '0) begin
              disp_d  = '1;
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = StA;
            end else if (iter_left) begin
              if (!div_trial[WIDTH]) begin
                hi_d = div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
              end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
              end
              cnt_d = cnt_q + 1'b1;
            end else begin
              disp_d  = lo_q;
              err_d   = 1'b0;
              busy_d  = 1'b0;
              state_d = StA;
            end
          end
          default: ;
        endcase
      end
      default: state_d = StA;
    endcase

    // Clear overrides everything, including a coincident enter.
    if (bus.clear) begin
      state_d = StA;
      disp_d  = '0;
      err_d   = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StA;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      disp_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      disp_q  <= disp_d;
      op_q    <= op_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.display = disp_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed vector table, multi-cycle corner sequences and
// random operations checked against an arithmetic reference model.
module tb_calc_core;

  localparam int W    = 8;
  localparam int Mask = (1 << W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  calc_core_if #(.WIDTH(W)) bus ();

  calc_core #(
    .WIDTH        (W),
    .ECHO_OPERANDS(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int op;
    int exp_disp;
    int exp_err;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned arithmetic; latency counted in edges after the B enter.
  task automatic model(input int a, input int b, input int op,
                       output int res, output int err, output int lat);
    int full;
    case (op)
      0: begin full = a + b; res = full & Mask; err = (full > Mask) ? 1 : 0; lat = 1; end
      1: begin res = (a - b) & Mask; err = (a < b) ? 1 : 0; lat = 1; end
      2: begin full = a * b; res = full & Mask; err = (full > Mask) ? 1 : 0; lat = W + 1; end
      default: begin
        if (b == 0) begin res = Mask; err = 1; lat = 1; end
        else begin res = a / b; err = 0; lat = W + 1; end
      end
    endcase
  endtask

  // Latch A then B/op; returns just after edge N (B sampled).
  task automatic start_op(input int a, input int b, input int op);
    bus.sw    = a[W-1:0];
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    check("echo_a", bus.display, a);
    check("err_cleared_on_a", bus.err, 0);
    check("idle_after_a", bus.busy, 0);
    bus.sw    = b[W-1:0];
    bus.op    = op[1:0];
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    bus.sw    = W'($urandom);
    check("busy_after_b", bus.busy, 1);
    check("echo_b", bus.display, b);
  endtask

  task automatic run_op(input int a, input int b, input int op,
                        input int exp_disp, input int exp_err, input int lat);
    start_op(a, b, op);
    for (int k = 1; k < lat; k++) begin
      step();
      check("busy_during_exec", bus.busy, 1);
      check("display_held", bus.display, b);
    end
    step();
    check("busy_done", bus.busy, 0);
    check("result", bus.display, exp_disp);
    check("err_flag", bus.err, exp_err);
  endtask

  vec_t vecs[8];

  initial begin
    int res, err, lat, a, b, op;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.sw    = '0;
    bus.op    = '0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;

    vecs[0] = '{100,  27, 0, 127, 0, 1};
    vecs[1] = '{200, 100, 0,  44, 1, 1};
    vecs[2] = '{  5,   7, 1, 254, 1, 1};
    vecs[3] = '{  7,   5, 1,   2, 0, 1};
    vecs[4] = '{ 15,  17, 2, 255, 0, W + 1};
    vecs[5] = '{ 16,  16, 2,   0, 1, W + 1};
    vecs[6] = '{200,   7, 3,  28, 0, W + 1};
    vecs[7] = '{  9,   0, 3, 255, 1, 1};

    #12;
    check("reset_display", bus.display, 0);
    check("reset_err", bus.err, 0);
    check("reset_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_disp, vecs[i].exp_err, vecs[i].lat);

    // Enter during a mul is ignored and not queued.
    start_op(15, 17, 2);
    step();
    step();
    bus.sw    = 8'd99;
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    for (int k = 4; k <= W; k++) begin
      step();
      check("busy_after_ignored_enter", bus.busy, 1);
    end
    step();
    check("mul_result_after_enter", bus.display, 255);
    check("mul_busy_after_enter", bus.busy, 0);
    step();
    check("no_queued_enter", bus.display, 255);

    // Clear aborts an in-flight mul.
    start_op(16, 16, 2);
    step();
    step();
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clear_display", bus.display, 0);
    check("clear_busy", bus.busy, 0);
    check("clear_err", bus.err, 0);
    for (int k = 0; k < W + 2; k++) step();
    check("no_result_after_clear", bus.display, 0);
    run_op(3, 4, 0, 7, 0, 1);

    // Asynchronous reset mid-div.
    start_op(200, 7, 3);
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_display", bus.display, 0);
    check("async_rst_err", bus.err, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) step();
    check("no_result_after_rst", bus.display, 0);
    check("idle_after_rst", bus.busy, 0);

    // Clear and enter together in S_B: clear wins, B not latched.
    bus.sw    = 8'd10;
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    check("echo_a_before_clear", bus.display, 10);
    bus.sw    = 8'd20;
    bus.op    = 2'b00;
    bus.enter = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    check("clear_enter_display", bus.display, 0);
    check("clear_enter_busy", bus.busy, 0);
    step();
    check("clear_enter_still_idle", bus.busy, 0);
    run_op(50, 60, 0, 110, 0, 1);

    // Random operations against the model.
    for (int n = 0; n < 40; n++) begin
      a  = $urandom_range(0, Mask);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, Mask);
      op = $urandom_range(0, 3);
      model(a, b, op, res, err, lat);
      run_op(a, b, op, res, err, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
